operand_forward_unit: RTL and testbench
=======================================

OPERAND_FORWARD_UNIT -- requirements
Module: operand_forward_unit

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, operand/result width in bits.
REQ-002 The block SHALL have parameter NUM_OPS, default 2, number of ALU operands (op 0 = top, op 1 = bot).
REQ-003 The block SHALL have parameter ADDR_W, default 4, register address width.
REQ-004 The block SHALL have one clock and a synchronous active-high reset: clock, reset.
REQ-005 Ports, in order (name  direction  width  meaning):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  ID stage holds an instruction
- id_ready  out  1  ID/EX accepts this cycle
- id_src_addr  in  NUM_OPS*ADDR_W  source register per operand, op k at [k*ADDR_W +: ADDR_W]
- id_src_data  in  NUM_OPS*DATA_W  register-file read data per operand
- id_dest_addr  in  ADDR_W  primary destination of the ID instruction
- id_is_load  in  1  ID instruction is a load
- ex_hold  in  1  downstream stall; freeze ID/EX
- ex_mem_we_top, ex_mem_we_bot  in  1 each  EX/MEM write enables
- ex_mem_addr_top, ex_mem_addr_bot  in  ADDR_W each  EX/MEM destinations
- ex_mem_top, ex_mem_bot  in  DATA_W each  EX/MEM results
- mem_wb_we_top, mem_wb_we_bot, mem_wb_addr_top, mem_wb_addr_bot, mem_wb_top, mem_wb_bot  in  same widths as EX/MEM  MEM/WB stage
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_operand  out  NUM_OPS*DATA_W  forwarded ALU operands
- ex_sel  out  NUM_OPS*5  per-operand one-hot source select, for debug

Function
REQ-006 The block SHALL register per operand the source address and data, plus dest address, is_load and valid (the ID/EX register).
REQ-007 Advance = !ex_hold; load_use = id_valid && ex_valid && ex_is_load_q && ex_dest_q != 0 && (any id_src_addr equals ex_dest_q).
REQ-008 id_ready SHALL equal !ex_hold && !load_use, combinationally.
REQ-009 On advance with id_valid && !load_use the register SHALL capture all ID fields and set ex_valid=1.
REQ-010 On advance with !id_valid or load_use the register SHALL set ex_valid=0 (bubble) and keep other fields unchanged.
REQ-011 With ex_hold=1 all captured fields and ex_valid SHALL hold, except the refresh in REQ-012.
REQ-012 Hold refresh: while ex_hold && ex_valid, a stored src_data k SHALL be overwritten by mem_wb_top (else mem_wb_bot) when that port writes stored src_addr k != 0; top wins if both match.
REQ-013 Per operand, select SHALL be the first match, in priority order: ex_mem_top (00010), ex_mem_bot (00100), mem_wb_top (01000), mem_wb_bot (10000), else stored data (00001); match = we && addr == stored src_addr.
REQ-014 Source address 0 SHALL never forward; select 00001.
REQ-015 With ex_valid=0, every ex_sel SHALL be 00001 and ex_operand SHALL show the stored data.
REQ-016 ex_operand and ex_sel SHALL be combinational from the registered fields and the current stage inputs, with zero added latency.
REQ-017 Captured data latency SHALL be 1 cycle: ID values at edge n appear on ex_operand after edge n.
REQ-018 All operands SHALL use the same priority; bot operands SHALL never be decoded from top-operand state.

Reset
REQ-019 With reset=1 at a rising edge: ex_valid=0, all stored fields 0; ex_operand SHALL read 0 and ex_sel 00001 per operand the next cycle.
REQ-020 reset SHALL override ex_hold, capture and refresh in the same cycle.
REQ-021 An instruction in ID/EX during reset SHALL be discarded; no bubble or replay after reset.

Verification
REQ-022 Capture: id_src r3=0x11, r5=0x22, no writes -> next cycle ex_operand {0x22,0x11}, ex_sel {00001,00001}.
REQ-023 Priority: stored src r3; ex_mem_top and mem_wb_top both write r3 (0xAA, 0xBB) -> operand 0xAA, sel 00010; drop ex_mem_we_top -> 0xBB, 01000.
REQ-024 Load-use: ID/EX holds load to r4; ID reads r4 -> id_ready=0, next ex_valid=0; following cycle captures with id_ready=1.
REQ-025 Hold refresh: ex_hold=1, stored r6=0x05; mem_wb_top writes r6=0x7E -> after the edge stored data 0x7E, persists after MEM/WB retires.
REQ-026 Zero reg: src r0, ex_mem_top writes r0=0xFF -> sel 00001, operand = stored data.
REQ-027 Reset mid-hold: ex_valid=1, ex_hold=1, reset pulse -> ex_valid=0, operands 0, id_ready=1 when ex_hold drops.

Source files
------------

// File: rtl/operand_forward_unit.sv
// ID/EX pipeline register with operand forwarding from EX/MEM and MEM/WB,
// load-use interlock, and refresh of held operands while the stage is stalled.
module operand_forward_unit #(
  parameter int DATA_W  = 8,
  parameter int NUM_OPS = 2,
  parameter int ADDR_W  = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      id_valid,
  output logic                      id_ready,
  input  logic [NUM_OPS*ADDR_W-1:0] id_src_addr,
  input  logic [NUM_OPS*DATA_W-1:0] id_src_data,
  input  logic [ADDR_W-1:0]         id_dest_addr,
  input  logic                      id_is_load,
  input  logic                      ex_hold,
  input  logic                      ex_mem_we_top,
  input  logic                      ex_mem_we_bot,
  input  logic [ADDR_W-1:0]         ex_mem_addr_top,
  input  logic [ADDR_W-1:0]         ex_mem_addr_bot,
  input  logic [DATA_W-1:0]         ex_mem_top,
  input  logic [DATA_W-1:0]         ex_mem_bot,
  input  logic                      mem_wb_we_top,
  input  logic                      mem_wb_we_bot,
  input  logic [ADDR_W-1:0]         mem_wb_addr_top,
  input  logic [ADDR_W-1:0]         mem_wb_addr_bot,
  input  logic [DATA_W-1:0]         mem_wb_top,
  input  logic [DATA_W-1:0]         mem_wb_bot,
  output logic                      ex_valid,
  output logic [NUM_OPS*DATA_W-1:0] ex_operand,
  output logic [NUM_OPS*5-1:0]      ex_sel
);

  logic [NUM_OPS*ADDR_W-1:0] r_src_addr;
  logic [NUM_OPS*DATA_W-1:0] r_src_data;
  logic [ADDR_W-1:0]         r_dest;
  logic                      r_is_load;
  logic                      r_valid;

  logic                      w_src_hit;
  logic                      w_load_use;
  logic                      w_advance;
  logic                      w_capture;
  logic [ADDR_W-1:0]         w_fwd_addr;
  logic [ADDR_W-1:0]         w_ref_addr;

  assign w_advance = !ex_hold;
  assign w_capture = id_valid && !w_load_use;
  assign id_ready  = !ex_hold && !w_load_use;
  assign ex_valid  = r_valid;

  // Load-use detect: any ID source names the destination of a load in EX.
  always_comb begin
    w_src_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_OPS; k++) begin
      if (id_src_addr[k*ADDR_W +: ADDR_W] == r_dest) w_src_hit = 1'b1;
    end
    w_load_use = id_valid && r_valid && r_is_load && (r_dest != '0) && w_src_hit;
  end

  // ID/EX register: capture, bubble, or hold with MEM/WB refresh of stored data.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_src_addr <= '0;
      r_src_data <= '0;
      r_dest     <= '0;
      r_is_load  <= 1'b0;
      r_valid    <= 1'b0;
    end else if (w_advance) begin
      if (w_capture) begin
        r_src_addr <= id_src_addr;
        r_src_data <= id_src_data;
        r_dest     <= id_dest_addr;
        r_is_load  <= id_is_load;
        r_valid    <= 1'b1;
      end else begin
        r_valid    <= 1'b0;
      end
    end else if (r_valid) begin
      // A stalled instruction would otherwise lose values retiring from MEM/WB.
      for (int unsigned k = 0; k < NUM_OPS; k++) begin
        if (r_src_addr[k*ADDR_W +: ADDR_W] != '0) begin
          if (mem_wb_we_top && mem_wb_addr_top == r_src_addr[k*ADDR_W +: ADDR_W])
            r_src_data[k*DATA_W +: DATA_W] <= mem_wb_top;
          else if (mem_wb_we_bot && mem_wb_addr_bot == r_src_addr[k*ADDR_W +: ADDR_W])
            r_src_data[k*DATA_W +: DATA_W] <= mem_wb_bot;
        end
      end
    end
  end

  // Per-operand forwarding mux: youngest producer first, r0 and bubbles never forward.
  always_comb begin
    ex_operand = r_src_data;
    ex_sel     = '0;
    w_fwd_addr = '0;
    w_ref_addr = '0;
    for (int unsigned k = 0; k < NUM_OPS; k++) begin
      w_fwd_addr          = r_src_addr[k*ADDR_W +: ADDR_W];
      ex_sel[k*5 +: 5]    = 5'b00001;
      if (r_valid && w_fwd_addr != '0) begin
        if (ex_mem_we_top && ex_mem_addr_top == w_fwd_addr) begin
          ex_operand[k*DATA_W +: DATA_W] = ex_mem_top;
          ex_sel[k*5 +: 5]               = 5'b00010;
        end else if (ex_mem_we_bot && ex_mem_addr_bot == w_fwd_addr) begin
          ex_operand[k*DATA_W +: DATA_W] = ex_mem_bot;
          ex_sel[k*5 +: 5]               = 5'b00100;
        end else if (mem_wb_we_top && mem_wb_addr_top == w_fwd_addr) begin
          ex_operand[k*DATA_W +: DATA_W] = mem_wb_top;
          ex_sel[k*5 +: 5]               = 5'b01000;
        end else if (mem_wb_we_bot && mem_wb_addr_bot == w_fwd_addr) begin
          ex_operand[k*DATA_W +: DATA_W] = mem_wb_bot;
          ex_sel[k*5 +: 5]               = 5'b10000;
        end
      end
    end
    w_ref_addr = w_fwd_addr;
  end

endmodule

// File: tb/tb_operand_forward_unit.sv
// Scoreboard bench for operand_forward_unit: expected EX-stage views are queued
// when stimulus is applied and compared when the DUT presents them.
module tb_operand_forward_unit;

  localparam int DATA_W  = 8;
  localparam int NUM_OPS = 2;
  localparam int ADDR_W  = 4;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      id_valid;
  logic                      id_ready;
  logic [NUM_OPS*ADDR_W-1:0] id_src_addr;
  logic [NUM_OPS*DATA_W-1:0] id_src_data;
  logic [ADDR_W-1:0]         id_dest_addr;
  logic                      id_is_load;
  logic                      ex_hold;
  logic                      ex_mem_we_top, ex_mem_we_bot;
  logic [ADDR_W-1:0]         ex_mem_addr_top, ex_mem_addr_bot;
  logic [DATA_W-1:0]         ex_mem_top, ex_mem_bot;
  logic                      mem_wb_we_top, mem_wb_we_bot;
  logic [ADDR_W-1:0]         mem_wb_addr_top, mem_wb_addr_bot;
  logic [DATA_W-1:0]         mem_wb_top, mem_wb_bot;
  logic                      ex_valid;
  logic [NUM_OPS*DATA_W-1:0] ex_operand;
  logic [NUM_OPS*5-1:0]      ex_sel;

  localparam logic [4:0] S_RF  = 5'b00001;
  localparam logic [4:0] S_EMT = 5'b00010;
  localparam logic [4:0] S_EMB = 5'b00100;
  localparam logic [4:0] S_MWT = 5'b01000;
  localparam logic [4:0] S_MWB = 5'b10000;

  typedef struct {
    string       tag;
    logic        ev;
    logic [15:0] op;
    logic [9:0]  sel;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  operand_forward_unit #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .ADDR_W(ADDR_W)) dut (
    .clock(clock), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_src_addr(id_src_addr), .id_src_data(id_src_data),
    .id_dest_addr(id_dest_addr), .id_is_load(id_is_load),
    .ex_hold(ex_hold),
    .ex_mem_we_top(ex_mem_we_top), .ex_mem_we_bot(ex_mem_we_bot),
    .ex_mem_addr_top(ex_mem_addr_top), .ex_mem_addr_bot(ex_mem_addr_bot),
    .ex_mem_top(ex_mem_top), .ex_mem_bot(ex_mem_bot),
    .mem_wb_we_top(mem_wb_we_top), .mem_wb_we_bot(mem_wb_we_bot),
    .mem_wb_addr_top(mem_wb_addr_top), .mem_wb_addr_bot(mem_wb_addr_bot),
    .mem_wb_top(mem_wb_top), .mem_wb_bot(mem_wb_bot),
    .ex_valid(ex_valid), .ex_operand(ex_operand), .ex_sel(ex_sel)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic ev, input logic [15:0] op, input logic [9:0] sel);
    exp_t e;
    e.tag = tag; e.ev = ev; e.op = op; e.sel = sel;
    sb.push_back(e);
  endtask

  task automatic sb_check();
    exp_t e;
    check_val("sb_nonempty", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val({e.tag, "_valid"}, 32'(ex_valid), 32'(e.ev));
      check_val({e.tag, "_op"},    32'(ex_operand), 32'(e.op));
      check_val({e.tag, "_sel"},   32'(ex_sel), 32'(e.sel));
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_fwd();
    ex_mem_we_top = 0; ex_mem_we_bot = 0; ex_mem_addr_top = '0; ex_mem_addr_bot = '0;
    ex_mem_top = '0; ex_mem_bot = '0;
    mem_wb_we_top = 0; mem_wb_we_bot = 0; mem_wb_addr_top = '0; mem_wb_addr_bot = '0;
    mem_wb_top = '0; mem_wb_bot = '0;
  endtask

  task automatic drive_id(input logic v, input logic [3:0] a1, input logic [3:0] a0,
                          input logic [7:0] d1, input logic [7:0] d0,
                          input logic [3:0] dest, input logic ld);
    id_valid = v; id_src_addr = {a1, a0}; id_src_data = {d1, d0};
    id_dest_addr = dest; id_is_load = ld;
  endtask

  initial begin
    reset = 1; ex_hold = 0;
    drive_id(0, 0, 0, 0, 0, 0, 0);
    clear_fwd();

    // Reset state
    sb_push("reset", 0, 16'h0000, {S_RF, S_RF});
    tick(); tick();
    sb_check();
    check_val("reset_ready", 32'(id_ready), 32'd1);

    // Capture: r3=0x11 (op0), r5=0x22 (op1)
    reset = 0;
    drive_id(1, 4'd5, 4'd3, 8'h22, 8'h11, 4'd7, 0);
    sb_push("capture", 1, 16'h2211, {S_RF, S_RF});
    tick();
    sb_check();
    drive_id(0, 0, 0, 0, 0, 0, 0);

    // Forwarding priority, observed combinationally on the held fields
    ex_mem_we_top = 1; ex_mem_addr_top = 4'd3; ex_mem_top = 8'hAA;
    mem_wb_we_top = 1; mem_wb_addr_top = 4'd3; mem_wb_top = 8'hBB;
    #1;
    sb_push("prio_exm_top", 1, 16'h22AA, {S_RF, S_EMT}); sb_check();
    ex_mem_we_top = 0;
    #1;
    sb_push("prio_mwb_top", 1, 16'h22BB, {S_RF, S_MWT}); sb_check();
    ex_mem_we_bot = 1; ex_mem_addr_bot = 4'd5; ex_mem_bot = 8'hCC;
    mem_wb_we_bot = 1; mem_wb_addr_bot = 4'd5; mem_wb_bot = 8'hDD;
    #1;
    sb_push("prio_exm_bot", 1, 16'hCCBB, {S_EMB, S_MWT}); sb_check();
    ex_mem_we_bot = 0;
    #1;
    sb_push("prio_mwb_bot", 1, 16'hDDBB, {S_MWB, S_MWT}); sb_check();

    // Bubble: no ID instruction, forwarding must be suppressed
    clear_fwd();
    ex_mem_we_top = 1; ex_mem_addr_top = 4'd3; ex_mem_top = 8'hAA;
    sb_push("bubble", 0, 16'h2211, {S_RF, S_RF});
    tick();
    sb_check();
    clear_fwd();

    // Load-use interlock
    drive_id(1, 4'd2, 4'd1, 8'h02, 8'h01, 4'd4, 1);
    sb_push("load_cap", 1, 16'h0201, {S_RF, S_RF});
    tick();
    sb_check();
    drive_id(1, 4'd4, 4'd9, 8'h44, 8'h99, 4'd8, 0);
    #1;
    check_val("lu_ready_low", 32'(id_ready), 32'd0);
    sb_push("lu_bubble", 0, 16'h0201, {S_RF, S_RF});
    tick();
    sb_check();
    check_val("lu_ready_high", 32'(id_ready), 32'd1);
    sb_push("lu_capture", 1, 16'h4499, {S_RF, S_RF});
    tick();
    sb_check();
    drive_id(0, 0, 0, 0, 0, 0, 0);

    // Hold refresh: r6=0x05 (op0), r2=0x33 (op1)
    drive_id(1, 4'd2, 4'd6, 8'h33, 8'h05, 4'd1, 0);
    sb_push("hr_cap", 1, 16'h3305, {S_RF, S_RF});
    tick();
    sb_check();
    drive_id(1, 4'd9, 4'd9, 8'h99, 8'h99, 4'd9, 0);
    ex_hold = 1;
    mem_wb_we_top = 1; mem_wb_addr_top = 4'd6; mem_wb_top = 8'h7E;
    #1;
    check_val("hold_ready", 32'(id_ready), 32'd0);
    sb_push("hr_fwd", 1, 16'h337E, {S_RF, S_MWT}); sb_check();
    tick();
    clear_fwd();
    #1;
    sb_push("hr_stored", 1, 16'h337E, {S_RF, S_RF}); sb_check();
    tick();
    sb_push("hr_persist", 1, 16'h337E, {S_RF, S_RF}); sb_check();
    mem_wb_we_top = 1; mem_wb_addr_top = 4'd2; mem_wb_top = 8'hA1;
    mem_wb_we_bot = 1; mem_wb_addr_bot = 4'd2; mem_wb_bot = 8'hB2;
    tick();
    clear_fwd();
    #1;
    sb_push("hr_top_wins", 1, 16'hA17E, {S_RF, S_RF}); sb_check();
    ex_hold = 0;
    drive_id(0, 0, 0, 0, 0, 0, 0);

    // Zero register never forwards nor refreshes
    drive_id(1, 4'd0, 4'd0, 8'h5A, 8'hC3, 4'd0, 0);
    sb_push("r0_cap", 1, 16'h5AC3, {S_RF, S_RF});
    tick();
    sb_check();
    drive_id(0, 0, 0, 0, 0, 0, 0);
    ex_hold = 1;
    ex_mem_we_top = 1; ex_mem_addr_top = 4'd0; ex_mem_top = 8'hFF;
    mem_wb_we_top = 1; mem_wb_addr_top = 4'd0; mem_wb_top = 8'hEE;
    #1;
    sb_push("r0_nofwd", 1, 16'h5AC3, {S_RF, S_RF}); sb_check();
    tick();
    clear_fwd();
    #1;
    sb_push("r0_norefresh", 1, 16'h5AC3, {S_RF, S_RF}); sb_check();
    ex_hold = 0;

    // Reset while holding a valid instruction
    drive_id(1, 4'd3, 4'd5, 8'h12, 8'h34, 4'd2, 1);
    sb_push("rh_cap", 1, 16'h1234, {S_RF, S_RF});
    tick();
    sb_check();
    ex_hold = 1; reset = 1;
    mem_wb_we_top = 1; mem_wb_addr_top = 4'd5; mem_wb_top = 8'h77;
    sb_push("rh_reset", 0, 16'h0000, {S_RF, S_RF});
    tick();
    reset = 0;
    clear_fwd();
    drive_id(0, 0, 0, 0, 0, 0, 0);
    #1;
    sb_check();
    check_val("rh_ready_held", 32'(id_ready), 32'd0);
    ex_hold = 0;
    #1;
    check_val("rh_ready_release", 32'(id_ready), 32'd1);
    sb_push("rh_no_replay", 0, 16'h0000, {S_RF, S_RF});
    tick();
    sb_check();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
